// File: rtl/hazard_pkg.sv
// Shared definitions for the five-stage core hazard controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, EX operand forward selects, base opcodes used by
// the decoder/ControlUnit, and the register-dependency helper.
package hazard_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // EX operand selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // RV64 base opcodes shared with the decoder and ControlUnit
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;

  // True when a producer writing rd feeds a consumer reading rs.
  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_dep(input logic [4:0] rd, input logic regwrite,
                                   input logic [4:0] rs, input logic use_rs);
    return regwrite && (rd != 5'd0) && use_rs && (rd == rs);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is ignored once saturated.
//
// Ports: clk, reset (sync, active-high), inc, count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller beside ID: stage enables, flush/bubble, EX forward selects.
// Latency: all control outputs combinational from inputs + shadow state; state updates on posedge clk.
// Backpressure: dmem_req && !dmem_ready freezes every stage; hazards stall PC and IF/ID only.
//
// Ports: clk, reset (sync, active-high); ID fields id_valid/id_rs1/id_rs2/id_rd/
// id_use_rs1/id_use_rs2/id_regwrite/id_memread; ex_branch_taken; dmem_req/dmem_ready;
// outputs pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush,
// idex_bubble, fwd_a, fwd_b, timeout_err, stall_cnt, flush_cnt.
// Build option: HAZARD_FORWARD_EN enables EX forwarding (load-use stalls only);
// without it fwd_a/fwd_b stay 00 and any EX/MEM producer match stalls ID.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  // Shadow pipeline. Source fields are stored as x0 when the instruction does
  // not read them, so forwarding never fires for an unused operand.
  logic [4:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze, hazard, stall_inc, flush_inc, ex_load;

  assign freeze = dmem_req && !dmem_ready;

  // An invalid ID slot is a bubble and cannot be a consumer.
`ifdef HAZARD_FORWARD_EN
  assign hazard = id_valid && ex_memread &&
                  (reg_dep(ex_rd, ex_regwrite, id_rs1, id_use_rs1) ||
                   reg_dep(ex_rd, ex_regwrite, id_rs2, id_use_rs2));

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!reset) begin
      // EX/MEM holds the younger value, so it wins over MEM/WB
      if (reg_dep(mem_rd, mem_regwrite, ex_rs1, 1'b1))     fwd_a = FWD_MEM;
      else if (reg_dep(wb_rd, wb_regwrite, ex_rs1, 1'b1))  fwd_a = FWD_WB;
      if (reg_dep(mem_rd, mem_regwrite, ex_rs2, 1'b1))     fwd_b = FWD_MEM;
      else if (reg_dep(wb_rd, wb_regwrite, ex_rs2, 1'b1))  fwd_b = FWD_WB;
    end
  end
`else
  assign hazard = id_valid &&
                  (reg_dep(ex_rd,  ex_regwrite,  id_rs1, id_use_rs1) ||
                   reg_dep(ex_rd,  ex_regwrite,  id_rs2, id_use_rs2) ||
                   reg_dep(mem_rd, mem_regwrite, id_rs1, id_use_rs1) ||
                   reg_dep(mem_rd, mem_regwrite, id_rs2, id_use_rs2));

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  // Shadow fields only consumed by the forwarding network in this build.
  logic unused_fwd_shadow;
  assign unused_fwd_shadow = ^{ex_memread, ex_rs1, ex_rs2, wb_rd, wb_regwrite};
`endif

  // Priority: reset > freeze > taken-branch flush > hazard stall > run.
  // A flush discards the wrong-path ID instruction, so its stall is dropped.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  // Memory-wait FSM: the first frozen cycle enters MEM_WAIT, each further
  // frozen cycle counts; timeout is sticky but the freeze keeps going.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (freeze) state <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (freeze) begin
            if (wait_cnt != WAIT_MAX)  wait_cnt    <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) timeout_err <= 1'b1;
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // EX takes a real instruction only when ID is valid and not bubbled.
  assign ex_load = id_valid && !idex_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else if (exmem_write) begin
      ex_rd        <= ex_load ? id_rd : 5'd0;
      ex_rs1       <= (ex_load && id_use_rs1) ? id_rs1 : 5'd0;
      ex_rs2       <= (ex_load && id_use_rs2) ? id_rs2 : 5'd0;
      ex_regwrite  <= ex_load && id_regwrite;
      ex_memread   <= ex_load && id_memread;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
